// File: rtl/dmio_arbiter_pkg.sv
// rtl/dmio_arbiter_pkg.sv - shared types and defaults for the data-memory / I/O arbiter
package dmio_arbiter_pkg;

   localparam int DATA_W_DEFAULT = 64;
   localparam int IO_BIT_DEFAULT = 12;
   localparam int MEM_AW_DEFAULT = 12;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   typedef enum logic {
      GNT_CPU = 1'b0,
      GNT_DBG = 1'b1
   } grant_e;

endpackage

// File: rtl/dmio_arbiter_if.sv
// rtl/dmio_arbiter_if.sv - CPU, debug and RAM buses around the arbiter
interface dmio_arbiter_if
   import dmio_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int MEM_AW = MEM_AW_DEFAULT
);
   logic              cpu_req;
   logic              cpu_wr;
   logic [63:0]       cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ready;
   logic [DATA_W-1:0] cpu_rdata;

   logic              dbg_req;
   logic              dbg_wr;
   logic [63:0]       dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic              dbg_ready;
   logic [DATA_W-1:0] dbg_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
      output cpu_ready, cpu_rdata,
      input  dbg_req, dbg_wr, dbg_addr, dbg_wdata,
      output dbg_ready, dbg_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
      input  cpu_ready, cpu_rdata,
      output dbg_req, dbg_wr, dbg_addr, dbg_wdata,
      input  dbg_ready, dbg_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/dmio_sync2.sv
// rtl/dmio_sync2.sv - two-flop synchronizer for asynchronous board inputs
module dmio_sync2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] meta;

   // first flop may go metastable; second flop gives it a full cycle to settle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/dmio_arbiter.sv
// rtl/dmio_arbiter.sv - round-robin CPU/debug arbiter for data RAM and LED/switch I/O
module dmio_arbiter
   import dmio_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int IO_BIT = IO_BIT_DEFAULT,
   parameter int MEM_AW = MEM_AW_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   dmio_arbiter_if.slave bus,
   input  logic [7:0]    switch,
   output logic [7:0]    leds
);
   state_e            state, next_state;
   grant_e            last_grant, winner;
   logic              any_req;
   logic [63:0]       sel_addr;
   logic              unused_addr;
   logic              lat_wr;
   logic              lat_io;
   logic [MEM_AW-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [DATA_W-1:0] io_cap;
   logic [DATA_W-1:0] resp_data;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] dbg_rdata_q;
   logic [7:0]        switch_sync;

   dmio_sync2 #(.W(8)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (switch),
      .q     (switch_sync)
   );

   // round-robin pick: a lone requester wins, a tie goes to the port not granted last
   always_comb begin
      winner = GNT_CPU;
      if (bus.cpu_req && bus.dbg_req) begin
         winner = (last_grant == GNT_CPU) ? GNT_DBG : GNT_CPU;
      end else if (bus.dbg_req) begin
         winner = GNT_DBG;
      end
   end

   assign any_req     = bus.cpu_req | bus.dbg_req;
   assign sel_addr    = (winner == GNT_DBG) ? bus.dbg_addr : bus.cpu_addr;
   assign unused_addr = ^sel_addr;
   assign resp_data   = lat_wr ? '0 : (lat_io ? io_cap : bus.mem_rdata);

   assign bus.mem_addr  = lat_addr;
   assign bus.mem_wdata = lat_wdata;

   // state register; reset drops any in-flight transaction
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // next state plus RAM strobes and response muxing, all decoded from the current state
   always_comb begin
      next_state    = state;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.cpu_ready = 1'b0;
      bus.dbg_ready = 1'b0;
      bus.cpu_rdata = cpu_rdata_q;
      bus.dbg_rdata = dbg_rdata_q;
      case (state)
         IDLE: begin
            if (any_req) next_state = ACCESS;
         end
         ACCESS: begin
            bus.mem_en = ~lat_io;
            bus.mem_we = ~lat_io & lat_wr;
            next_state = RESP;
         end
         RESP: begin
            if (last_grant == GNT_CPU) begin
               bus.cpu_ready = 1'b1;
               bus.cpu_rdata = resp_data;
            end else begin
               bus.dbg_ready = 1'b1;
               bus.dbg_rdata = resp_data;
            end
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // operand latch, I/O side effects and per-port read-data hold
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant  <= GNT_DBG;
         lat_wr      <= 1'b0;
         lat_io      <= 1'b0;
         lat_addr    <= '0;
         lat_wdata   <= '0;
         io_cap      <= '0;
         leds        <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  last_grant <= winner;
                  lat_wr     <= (winner == GNT_DBG) ? bus.dbg_wr : bus.cpu_wr;
                  lat_wdata  <= (winner == GNT_DBG) ? bus.dbg_wdata : bus.cpu_wdata;
                  lat_io     <= sel_addr[IO_BIT];
                  lat_addr   <= sel_addr[MEM_AW-1:0];
               end
            end
            ACCESS: begin
               if (lat_io) begin
                  if (lat_wr) leds <= lat_wdata[7:0];
                  else        io_cap <= DATA_W'(switch_sync);
               end
            end
            RESP: begin
               if (last_grant == GNT_CPU) cpu_rdata_q <= resp_data;
               else                       dbg_rdata_q <= resp_data;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmio_arbiter.sv
// tb/tb_dmio_arbiter.sv - self-checking bench for dmio_arbiter
module tb_dmio_arbiter;
   import dmio_arbiter_pkg::*;

   typedef struct {
      bit          wr;
      logic [63:0] addr;
      logic [63:0] data;
   } txn_t;

   typedef struct {
      bit          port;
      bit          wr;
      logic [63:0] addr;
      logic [63:0] data;
      logic [7:0]  sw;
      logic [63:0] exp_rdata;
      logic [7:0]  exp_leds;
      int          exp_en;
      logic [11:0] exp_maddr;
   } vec_t;

   typedef struct {
      int          c_cyc;
      int          d_cyc;
      int          c_cnt;
      int          d_cnt;
      int          en_cnt;
      int          we_cnt;
      int          both;
      logic [63:0] c_data;
      logic [63:0] d_data;
      logic [11:0] maddr;
   } obs_t;

   typedef struct {
      int          port;
      int          cyc;
      logic [63:0] data;
   } grant_rec_t;

   logic       clk;
   logic       reset;
   logic [7:0] switch;
   logic [7:0] leds;

   int n_vec = 0;
   int n_err = 0;

   logic [63:0] ram     [0:4095];
   logic [63:0] ref_mem [0:4095];
   logic [7:0]  m_leds;
   logic [7:0]  m_sw;
   logic [63:0] m_cpu_rd;
   logic [63:0] m_dbg_rd;
   grant_e      m_last;

   dmio_arbiter_if #(.DATA_W(64), .MEM_AW(12)) bus ();

   dmio_arbiter #(.DATA_W(64), .IO_BIT(12), .MEM_AW(12)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus),
      .switch (switch),
      .leds   (leds)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
         bus.mem_rdata <= ram[bus.mem_addr];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model_apply(input int port, input txn_t t);
      logic [63:0] r;
      r = '0;
      if (t.wr) begin
         if (t.addr[12]) m_leds = t.data[7:0];
         else            ref_mem[t.addr[11:0]] = t.data;
      end else begin
         r = t.addr[12] ? {56'b0, m_sw} : ref_mem[t.addr[11:0]];
      end
      if (port == 0) m_cpu_rd = r;
      else           m_dbg_rd = r;
      m_last = (port == 0) ? GNT_CPU : GNT_DBG;
      return r;
   endfunction

   task automatic serve(input bit use_c, input bit use_d, input txn_t tc, input txn_t td,
                        input bit drop_early, input string tag, output obs_t o);
      bit          c_first;
      bit          pend;
      logic [63:0] exp_c, exp_d;
      int          exp_c_cyc, exp_d_cyc, exp_en, exp_we;
      o = '{-1, -1, 0, 0, 0, 0, 0, 64'h0, 64'h0, 12'h0};
      exp_c = '0; exp_d = '0; exp_c_cyc = -1; exp_d_cyc = -1;
      c_first = use_c && (!use_d || m_last == GNT_DBG);
      if (c_first) begin
         exp_c = model_apply(0, tc); exp_c_cyc = 2;
         if (use_d) begin exp_d = model_apply(1, td); exp_d_cyc = 5; end
      end else begin
         if (use_d) begin exp_d = model_apply(1, td); exp_d_cyc = 2; end
         if (use_c) begin exp_c = model_apply(0, tc); exp_c_cyc = 5; end
      end
      exp_en = 0; exp_we = 0;
      if (use_c && !tc.addr[12]) begin exp_en++; if (tc.wr) exp_we++; end
      if (use_d && !td.addr[12]) begin exp_en++; if (td.wr) exp_we++; end

      bus.cpu_req = use_c; bus.cpu_wr = tc.wr; bus.cpu_addr = tc.addr; bus.cpu_wdata = tc.data;
      bus.dbg_req = use_d; bus.dbg_wr = td.wr; bus.dbg_addr = td.addr; bus.dbg_wdata = td.data;
      pend = 1'b1;
      for (int c = 1; c <= 12 && pend; c++) begin
         @(negedge clk);
         if (drop_early && c == 1) bus.cpu_req = 1'b0;
         if (bus.mem_en === 1'b1) begin
            o.en_cnt++;
            o.maddr = bus.mem_addr;
            if (bus.mem_we === 1'b1) o.we_cnt++;
         end
         if (bus.cpu_ready === 1'b1 && bus.dbg_ready === 1'b1) o.both++;
         if (bus.cpu_ready === 1'b1) begin
            o.c_cnt++; o.c_cyc = c; o.c_data = bus.cpu_rdata; bus.cpu_req = 1'b0;
         end
         if (bus.dbg_ready === 1'b1) begin
            o.d_cnt++; o.d_cyc = c; o.d_data = bus.dbg_rdata; bus.dbg_req = 1'b0;
         end
         pend = (use_c && o.c_cnt == 0) || (use_d && o.d_cnt == 0);
      end
      @(negedge clk);
      if (bus.cpu_ready === 1'b1) o.c_cnt++;
      if (bus.dbg_ready === 1'b1) o.d_cnt++;
      if (bus.mem_en === 1'b1) o.en_cnt++;

      check({tag, " cpu_ready_cycle"}, o.c_cyc, exp_c_cyc);
      check({tag, " cpu_ready_pulses"}, o.c_cnt, {63'b0, use_c});
      check({tag, " dbg_ready_cycle"}, o.d_cyc, exp_d_cyc);
      check({tag, " dbg_ready_pulses"}, o.d_cnt, {63'b0, use_d});
      if (use_c) check({tag, " cpu_rdata"}, o.c_data, exp_c);
      if (use_d) check({tag, " dbg_rdata"}, o.d_data, exp_d);
      check({tag, " both_ready"}, o.both, 0);
      check({tag, " mem_en_cycles"}, o.en_cnt, exp_en);
      check({tag, " mem_we_cycles"}, o.we_cnt, exp_we);
      check({tag, " leds"}, {56'b0, leds}, {56'b0, m_leds});
      check({tag, " cpu_rdata_hold"}, bus.cpu_rdata, m_cpu_rd);
      check({tag, " dbg_rdata_hold"}, bus.dbg_rdata, m_dbg_rd);
   endtask

   task automatic set_switch(input logic [7:0] v);
      switch = v;
      m_sw   = v;
      repeat (3) @(negedge clk);
   endtask

   function automatic txn_t rand_txn();
      txn_t t;
      t.wr   = 1'($urandom_range(0, 1));
      t.addr = {$urandom, $urandom};
      t.addr[12] = ($urandom_range(0, 3) == 0);
      t.addr[11:0] = ($urandom_range(0, 4) == 0) ? 12'hFF8 : {6'b0, 3'($urandom_range(0, 7)), 3'b0};
      t.data = {$urandom, $urandom};
      return t;
   endfunction

   task automatic reset_test();
      txn_t t;
      obs_t o;
      int   rdy;
      t = '{1'b0, 64'h010, 64'h0};
      bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 64'h010; bus.cpu_wdata = '0;
      @(negedge clk);
      check("rst pre_state", {62'b0, dut.state}, {62'b0, ACCESS});
      reset = 1'b1;
      #1;
      check("rst state", {62'b0, dut.state}, {62'b0, IDLE});
      check("rst cpu_ready", {63'b0, bus.cpu_ready}, 64'h0);
      check("rst mem_en", {63'b0, bus.mem_en}, 64'h0);
      check("rst mem_we", {63'b0, bus.mem_we}, 64'h0);
      check("rst leds", {56'b0, leds}, 64'h0);
      check("rst cpu_rdata", bus.cpu_rdata, 64'h0);
      check("rst dbg_rdata", bus.dbg_rdata, 64'h0);
      m_leds = '0; m_cpu_rd = '0; m_dbg_rd = '0; m_last = GNT_DBG;
      bus.cpu_req = 1'b0;
      rdy = 0;
      repeat (2) begin
         @(negedge clk);
         if (bus.cpu_ready === 1'b1 || bus.dbg_ready === 1'b1) rdy++;
      end
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.cpu_ready === 1'b1 || bus.dbg_ready === 1'b1) rdy++;
      end
      check("rst no_ready", rdy, 0);
      serve(1'b1, 1'b0, t, t, 1'b0, "post_rst", o);
   endtask

   task automatic tie_test();
      grant_rec_t  q[$];
      txn_t        tc, td;
      logic [63:0] exp;
      int          p;
      int          n_seen;
      tc = '{1'b0, 64'h010, 64'h0};
      td = '{1'b0, 64'h1000, 64'h0};
      bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = tc.addr; bus.cpu_wdata = '0;
      bus.dbg_req = 1'b1; bus.dbg_wr = 1'b0; bus.dbg_addr = td.addr; bus.dbg_wdata = '0;
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         if (bus.cpu_ready === 1'b1) q.push_back('{0, c, bus.cpu_rdata});
         if (bus.dbg_ready === 1'b1) q.push_back('{1, c, bus.dbg_rdata});
         if (c == 11) begin bus.cpu_req = 1'b0; bus.dbg_req = 1'b0; end
      end
      n_seen = q.size();
      check("tie grant_count", n_seen, 4);
      while (q.size() < 4) q.push_back('{-1, -1, 64'h0});
      p = (m_last == GNT_DBG) ? 0 : 1;
      for (int i = 0; i < 4; i++) begin
         exp = model_apply(p, (p == 0) ? tc : td);
         check($sformatf("tie%0d port", i), q[i].port, p);
         check($sformatf("tie%0d cycle", i), q[i].cyc, 2 + 3 * i);
         check($sformatf("tie%0d rdata", i), q[i].data, exp);
         p = 1 - p;
      end
   endtask

   initial begin
      vec_t vecs[10];
      obs_t o;
      txn_t t, tc, td;
      int   mode;

      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[10];
      obs_t o;
      txn_t t, tc, td;
      int   mode;

      for (int i = 0; i < 4096; i++) begin
         ram[i] = '0;
         ref_mem[i] = '0;
      end
      m_leds = '0; m_sw = '0; m_cpu_rd = '0; m_dbg_rd = '0; m_last = GNT_DBG;
      bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dbg_req = 1'b0; bus.dbg_wr = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
      switch = '0;
      reset  = 1'b1;
      repeat (3) @(negedge clk);
      check("init state", {62'b0, dut.state}, {62'b0, IDLE});
      check("init cpu_ready", {63'b0, bus.cpu_ready}, 64'h0);
      check("init dbg_ready", {63'b0, bus.dbg_ready}, 64'h0);
      check("init mem_en", {63'b0, bus.mem_en}, 64'h0);
      check("init leds", {56'b0, leds}, 64'h0);
      check("init cpu_rdata", bus.cpu_rdata, 64'h0);
      reset = 1'b0;
      @(negedge clk);

      vecs[0] = '{1'b0, 1'b1, 64'h010,                 64'hDEAD_BEEF,           8'h00, 64'h0,                   8'h00, 1, 12'h010};
      vecs[1] = '{1'b0, 1'b0, 64'h010,                 64'h0,                   8'h00, 64'hDEAD_BEEF,           8'h00, 1, 12'h010};
      vecs[2] = '{1'b1, 1'b1, 64'h1000,                64'hA5,                  8'h00, 64'h0,                   8'hA5, 0, 12'h000};
      vecs[3] = '{1'b0, 1'b0, 64'h1000,                64'h0,                   8'h3C, 64'h3C,                  8'hA5, 0, 12'h000};
      vecs[4] = '{1'b1, 1'b1, 64'h0FF8,                64'h1234_5678_9ABC_DEF0, 8'h3C, 64'h0,                   8'hA5, 1, 12'hFF8};
      vecs[5] = '{1'b0, 1'b0, 64'hFFFF_0000_0000_0FF8, 64'h0,                   8'h3C, 64'h1234_5678_9ABC_DEF0, 8'hA5, 1, 12'hFF8};
      vecs[6] = '{1'b0, 1'b1, 64'h2010,                64'h55,                  8'h3C, 64'h0,                   8'hA5, 1, 12'h010};
      vecs[7] = '{1'b1, 1'b0, 64'h010,                 64'h0,                   8'h3C, 64'h55,                  8'hA5, 1, 12'h010};
      vecs[8] = '{1'b1, 1'b1, 64'h3000,                64'h1FF,                 8'h3C, 64'h0,                   8'hFF, 0, 12'h000};
      vecs[9] = '{1'b1, 1'b0, 64'hF000,                64'h0,                   8'hC3, 64'hC3,                  8'hFF, 0, 12'h000};

      for (int i = 0; i < 10; i++) begin
         set_switch(vecs[i].sw);
         t = '{vecs[i].wr, vecs[i].addr, vecs[i].data};
         serve(vecs[i].port == 1'b0, vecs[i].port == 1'b1, t, t, 1'b0, $sformatf("vec%0d", i), o);
         check($sformatf("vec%0d table_rdata", i), vecs[i].port ? o.d_data : o.c_data, vecs[i].exp_rdata);
         check($sformatf("vec%0d table_leds", i), {56'b0, leds}, {56'b0, vecs[i].exp_leds});
         check($sformatf("vec%0d table_mem_en", i), o.en_cnt, vecs[i].exp_en);
         if (vecs[i].exp_en == 1) check($sformatf("vec%0d table_mem_addr", i), {52'b0, o.maddr}, {52'b0, vecs[i].exp_maddr});
      end

      t = '{1'b0, 64'h010, 64'h0};
      serve(1'b1, 1'b0, t, t, 1'b1, "drop_early", o);

      reset_test();
      tie_test();

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) set_switch(8'($urandom));
         mode = $urandom_range(0, 2);
         tc = rand_txn();
         td = rand_txn();
         serve(mode != 1, mode != 0, tc, td, (mode == 0) && ($urandom_range(0, 3) == 0),
               $sformatf("rnd%0d", i), o);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmio_arbiter.md
DMIO_ARBITER -- requirements
Module: dmio_arbiter

Interface
REQ-001 Parameter DATA_W, default 64, width of data buses.
REQ-002 Parameter IO_BIT, default 12, address bit selecting the I/O region (1) or data RAM (0).
REQ-003 Parameter MEM_AW, default 12, width of the RAM address (address[MEM_AW-1:0]).
REQ-004 Ports: clk input 1, system clock; all state changes on the rising edge.
REQ-005 Ports: reset input 1, asynchronous, active-high.
REQ-006 Ports: cpu_req in 1; cpu_wr in 1; cpu_addr in 64; cpu_wdata in DATA_W; cpu_ready out 1; cpu_rdata out DATA_W (CPU load/store port).
REQ-007 Ports: dbg_req in 1; dbg_wr in 1; dbg_addr in 64; dbg_wdata in DATA_W; dbg_ready out 1; dbg_rdata out DATA_W (debug/loader port).
REQ-008 Ports: mem_en out 1; mem_we out 1; mem_addr out MEM_AW; mem_wdata out DATA_W; mem_rdata in DATA_W (synchronous RAM, rdata valid one cycle after mem_en).
REQ-009 Ports: switch in 8, raw board switches; leds out 8, registered LED outputs.

Function
REQ-010 FSM states SHALL be IDLE, ACCESS, RESP; reset state IDLE.
REQ-011 IDLE: if any req high, latch winner's wr/addr/wdata, record grant, go ACCESS; else stay IDLE.
REQ-012 Arbitration SHALL be round-robin: single requester wins; both requesting -> port not granted last wins; last_grant resets to dbg (so CPU wins first tie).
REQ-013 ACCESS, RAM region (addr[IO_BIT]=0): mem_en=1, mem_we=latched wr, mem_addr=addr[MEM_AW-1:0], mem_wdata=latched wdata, for exactly one cycle; go RESP.
REQ-014 ACCESS, I/O region: mem_en=0; write -> leds <= wdata[7:0] at end of ACCESS; read -> capture {56'b0, switch_sync} ; go RESP.
REQ-015 RESP: granted port's ready=1 for exactly one cycle; rdata = mem_rdata (RAM read), switch capture (I/O read), or 0 (any write); go IDLE.
REQ-016 Latency: request sampled in IDLE cycle N -> ready in cycle N+2; back-to-back throughput one access per 3 cycles.
REQ-017 Non-granted port's ready SHALL stay 0; its rdata SHALL hold last value delivered to it.
REQ-018 Requesters SHALL hold req and operands stable until ready; arbiter SHALL use only latched operands after IDLE, so dropping req mid-transaction does not abort it.
REQ-019 A req still high in the cycle after ready SHALL be treated as a new request.
REQ-020 Address bits above IO_BIT SHALL be ignored; bits [MEM_AW-1:0] pass unchanged (no wrap logic beyond truncation).
REQ-021 switch SHALL pass a 2-flop synchronizer before use; I/O read returns synchronized value.
REQ-022 mem_en, mem_we SHALL be 0 in IDLE and RESP.

Reset
REQ-023 On reset assertion, immediately: state=IDLE, cpu_ready=dbg_ready=0, mem_en=mem_we=0, leds=0, rdata outputs=0, synchronizer=0, last_grant=dbg.
REQ-024 Reset mid-transaction SHALL abort it with no ready pulse and no LED update; a RAM write already issued in ACCESS is not undone.

Structure
REQ-025 Shared package SHALL hold FSM state enum (IDLE/ACCESS/RESP), grant encoding (GNT_CPU/GNT_DBG) and IO_BIT default.
REQ-026 One sub-module dmio_sync2 (2-flop synchronizer, width 8) SHALL be instantiated for switch; RAM stays external.

Verification
REQ-027 CPU write addr 0x010, data 0xDEAD_BEEF, then read 0x010 -> mem_we pulse in ACCESS, read ready at N+2 with cpu_rdata 0xDEAD_BEEF.
REQ-028 Both req same cycle, repeated 4 times -> grants CPU, DBG, CPU, DBG; each ready exactly 1 cycle, only to winner.
REQ-029 DBG write addr 0x1000 data 0xA5 -> leds=0xA5 after ACCESS, mem_en never 1; switch=0x3C held 3 cycles then CPU read 0x1000 -> cpu_rdata 0x3C.
REQ-030 Reset asserted during ACCESS of CPU read -> outputs zero at once, no cpu_ready, FSM IDLE, next request served normally.
REQ-031 CPU read addr 0xFFFF_0000_0000_0FF8 -> mem_addr 0xFF8, RAM region used (bit 12 = 0).
REQ-032 cpu_req dropped after IDLE sample -> transaction still completes with cpu_ready at N+2.
